// File: rtl/fp_add_arbiter_pkg.sv
// Shared types and constants for the fp_add_arbiter slice: FSM states, operand width,
// operation encodings and the packed-operand slice helper.
package fp_arb_pkg;

    localparam int FP_W    = 32;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // Operand k lives at [32k+31:32k]; callers widen their bus to MAX_REQ slots first.
    function automatic logic [FP_W-1:0] get_operand(input logic [FP_W*MAX_REQ-1:0] vec,
                                                    input logic [IDX_W-1:0]        idx);
        return vec[{idx, 5'd0} +: FP_W];
    endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Request/response channel bundle between the requesters (master) and the
// fp_add_arbiter (slave).
interface fp_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    import fp_arb_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [FP_W*NUM_REQ-1:0] req_data_a;
    logic [FP_W*NUM_REQ-1:0] req_data_b;
    logic [NUM_REQ-1:0]      req_op;
    logic [NUM_REQ-1:0]      req_ready;

    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [FP_W-1:0]         rsp_result;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_data_a, req_data_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_data_a, req_data_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational winner selection: round-robin search from i_ptr, or a plain
// lowest-index priority encoder when FP_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
`ifndef FP_ARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0]    i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    logic            w_found;
    logic [ID_W-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            w_k = ID_W'(i);
`else
            w_k = ID_W'((int'(i_ptr) + i) % NUM_REQ);
`endif
            if (!w_found && i_req[w_k]) begin
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Time-shares one external combinational fpAdder among NUM_REQ requesters.
// Define FP_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDER_LAT = 1,
    parameter int ID_W      = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    fp_add_arbiter_if.slave  bus,
    output logic [FP_W-1:0]  o_fp_data_a,
    output logic [FP_W-1:0]  o_fp_data_b,
    output logic             o_fp_operation,
    input  logic [FP_W-1:0]  i_fp_result
);

    localparam int CNT_W = 4;

    state_t             r_state;
    logic [ID_W-1:0]    r_id;
    logic [CNT_W-1:0]   r_lat_cnt;
    logic [FP_W-1:0]    r_fp_a;
    logic [FP_W-1:0]    r_fp_b;
    logic               r_fp_op;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [FP_W-1:0]    r_rsp_result;
`ifndef FP_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    r_ptr;
`endif

    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_W-1:0]         w_idx;
    logic [FP_W*MAX_REQ-1:0] w_a_ext;
    logic [FP_W*MAX_REQ-1:0] w_b_ext;

    assign w_a_ext = (FP_W*MAX_REQ)'(bus.req_data_a);
    assign w_b_ext = (FP_W*MAX_REQ)'(bus.req_data_b);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (bus.req_valid),
`ifndef FP_ARB_FIXED_PRIO_EN
        .i_ptr   (r_ptr),
`endif
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Ready is only offered in IDLE and is forced low while reset is held.
    assign bus.req_ready  = (r_state == IDLE && i_rst_n) ? w_grant : '0;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;

    assign o_fp_data_a    = r_fp_a;
    assign o_fp_data_b    = r_fp_b;
    assign o_fp_operation = r_fp_op;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_id         <= '0;
            r_lat_cnt    <= '0;
            r_fp_a       <= '0;
            r_fp_b       <= '0;
            r_fp_op      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
            r_ptr        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_fp_a    <= get_operand(w_a_ext, IDX_W'(w_idx));
                        r_fp_b    <= get_operand(w_b_ext, IDX_W'(w_idx));
                        r_fp_op   <= bus.req_op[w_idx];
                        r_id      <= w_idx;
                        r_lat_cnt <= CNT_W'(ADDER_LAT - 1);
`ifndef FP_ARB_FIXED_PRIO_EN
                        r_ptr     <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
`endif
                        r_state   <= EXEC;
                    end
                end
                // The adder output is only trusted once the latency budget has elapsed.
                EXEC: begin
                    if (r_lat_cnt == '0) begin
                        r_rsp_result <= i_fp_result;
                        r_rsp_id     <= r_id;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter with a 3-cycle behavioural fpAdder;
// honours FP_ARB_FIXED_PRIO_EN in its arbitration model.
module tb_fp_add_arbiter;
    import fp_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LAT     = 3;
    localparam int ID_W    = 2;

    typedef struct {
        int          reqIdx;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          stall;
        logic [1:0]  expId;
        logic [31:0] expRes;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] fpA, fpB, fpResult;
    logic        fpOp;
    logic [31:0] adderStage1, adderStage2;

    int checks   = 0;
    int failures = 0;
    int mdlPtr   = 0;

    logic [31:0] reqA [NUM_REQ];
    logic [31:0] reqB [NUM_REQ];
    logic        reqOp[NUM_REQ];

    fp_add_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    fp_add_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDER_LAT (LAT),
        .ID_W      (ID_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .bus            (bus),
        .o_fp_data_a    (fpA),
        .o_fp_data_b    (fpB),
        .o_fp_operation (fpOp),
        .i_fp_result    (fpResult)
    );

    always #5 i_clk = ~i_clk;

    // Single-precision <-> real conversion, exact for the normal values used here.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int          e;
        if (f[30:0] == 31'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpModel(input logic [31:0] a, input logic [31:0] b, input logic op);
        return r2f((op == OP_SUB) ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    // Slow adder: result settles LAT-1 cycles after the operand registers change.
    always @(posedge i_clk) begin
        adderStage1 <= fpModel(fpA, fpB, fpOp);
        adderStage2 <= adderStage1;
    end
    assign fpResult = adderStage2;

    function automatic int modelWinner(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            if (v[i]) return i;
`else
            if (v[(mdlPtr + i) % NUM_REQ]) return (mdlPtr + i) % NUM_REQ;
`endif
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic driveRequests(input logic [NUM_REQ-1:0] v);
        bus.req_valid = v;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data_a[i*32 +: 32] = reqA[i];
            bus.req_data_b[i*32 +: 32] = reqB[i];
            bus.req_op[i]              = reqOp[i];
        end
    endtask

    // Called just after a falling edge with the block idle and rsp_ready low.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valids, input int stall,
                                 output int gotId, output logic [31:0] gotRes);
        int                 w;
        int                 cnt;
        logic [31:0]        expRes;
        logic [NUM_REQ-1:0] expReady;
        driveRequests(valids);
        #1;
        w = modelWinner(valids);
        expReady = '0;
        if (w >= 0) expReady[w] = 1'b1;
        checkOutput("grant_onehot", 64'(bus.req_ready), 64'(expReady));
        if (w < 0) w = 0;
        expRes = fpModel(reqA[w], reqB[w], reqOp[w]);
        @(posedge i_clk);
        @(negedge i_clk);
        mdlPtr = (w + 1) % NUM_REQ;
        valids[w] = 1'b0;
        driveRequests(valids);
        #1;
        checkOutput("ready_after_grant", 64'(bus.req_ready), 64'h0);
        checkOutput("fp_a_latched", 64'(fpA), 64'(reqA[w]));
        checkOutput("fp_b_latched", 64'(fpB), 64'(reqB[w]));
        checkOutput("fp_op_latched", 64'(fpOp), 64'(reqOp[w]));
        cnt = 1;
        while (!bus.rsp_valid && cnt < 40) begin
            @(negedge i_clk);
            #1;
            cnt++;
        end
        checkOutput("rsp_latency", 64'(cnt), 64'(LAT + 1));
        checkOutput("rsp_id", 64'(bus.rsp_id), 64'(w));
        checkOutput("rsp_result", 64'(bus.rsp_result), 64'(expRes));
        gotId  = int'(bus.rsp_id);
        gotRes = bus.rsp_result;
        for (int s = 0; s < stall; s++) begin
            @(negedge i_clk);
            #1;
            checkOutput("hold_valid", 64'(bus.rsp_valid), 64'h1);
            checkOutput("hold_id", 64'(bus.rsp_id), 64'(w));
            checkOutput("hold_result", 64'(bus.rsp_result), 64'(expRes));
            checkOutput("hold_ready", 64'(bus.req_ready), 64'h0);
            checkOutput("hold_fp_a", 64'(fpA), 64'(reqA[w]));
            checkOutput("hold_fp_b", 64'(fpB), 64'(reqB[w]));
        end
        bus.rsp_ready = 1'b1;
        @(negedge i_clk);
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("rsp_released", 64'(bus.rsp_valid), 64'h0);
        w = modelWinner(valids);
        expReady = '0;
        if (w >= 0) expReady[w] = 1'b1;
        checkOutput("idle_after_release", 64'(bus.req_ready), 64'(expReady));
    endtask

    initial begin
        vec_t        vectors[6];
        int          order[$];
        int          expOrder[5];
        int          lastCyc;
        int          gotId;
        logic [31:0] gotRes;
        logic        sawValid;
        logic [NUM_REQ-1:0] mask;

        vectors[0] = '{0, 32'h3F800000, 32'h40000000, OP_ADD, 0, 2'd0, 32'h40400000};
        vectors[1] = '{2, 32'h40400000, 32'h3F800000, OP_SUB, 0, 2'd2, 32'h40000000};
        vectors[2] = '{1, 32'h41200000, 32'h40A00000, OP_SUB, 5, 2'd1, 32'h40A00000};
        vectors[3] = '{3, 32'hC0000000, 32'h40000000, OP_ADD, 0, 2'd3, 32'h00000000};
        vectors[4] = '{0, 32'h42C80000, 32'h3F000000, OP_ADD, 2, 2'd0, 32'h42C90000};
        vectors[5] = '{1, 32'h40400000, 32'hC0800000, OP_SUB, 1, 2'd1, 32'h40E00000};
`ifdef FP_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0, 0};
`else
        expOrder = '{0, 1, 2, 3, 0};
`endif

        i_rst_n       = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqA[i]  = 32'h0;
            reqB[i]  = 32'h0;
            reqOp[i] = OP_ADD;
        end
        driveRequests('1);
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("reset_ready", 64'(bus.req_ready), 64'h0);
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("reset_rsp_id", 64'(bus.rsp_id), 64'h0);
        checkOutput("reset_rsp_result", 64'(bus.rsp_result), 64'h0);
        checkOutput("reset_fp_a", 64'(fpA), 64'h0);
        checkOutput("reset_fp_b", 64'(fpB), 64'h0);
        checkOutput("reset_fp_op", 64'(fpOp), 64'h0);
        driveRequests('0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;

        $display("[TB] fairness with all requesters valid and rsp_ready high");
        for (int i = 0; i < NUM_REQ; i++) begin
            reqA[i]  = r2f(real'(i + 1));
            reqB[i]  = r2f(2.0);
            reqOp[i] = OP_ADD;
        end
        bus.rsp_ready = 1'b1;
        driveRequests('1);
        #1;
        lastCyc = 0;
        for (int cyc = 0; cyc < 60 && order.size() < 5; cyc++) begin
            if (bus.req_ready != '0) begin
                checkOutput("fair_onehot", 64'($countones(bus.req_ready)), 64'h1);
                if (order.size() > 0) checkOutput("issue_interval", 64'(cyc - lastCyc), 64'(LAT + 2));
                for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) order.push_back(k);
                lastCyc = cyc;
            end
            @(negedge i_clk);
            #1;
        end
        checkOutput("fair_count", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            checkOutput("fair_order", 64'(order[k]), 64'(expOrder[k]));
        driveRequests('0);
        repeat (LAT + 3) @(negedge i_clk);
        #1;
        checkOutput("fair_drained", 64'(bus.rsp_valid), 64'h0);
        bus.rsp_ready = 1'b0;

        $display("[TB] reset while executing");
        reqA[1]  = r2f(1.0);
        reqB[1]  = r2f(2.0);
        reqOp[1] = OP_ADD;
        driveRequests(4'b0010);
        #1;
        checkOutput("rst_pre_grant", 64'(bus.req_ready), 64'h2);
        @(posedge i_clk);
        @(negedge i_clk);
        driveRequests('0);
        #2;
        i_rst_n = 1'b0;
        driveRequests('1);
        #1;
        checkOutput("rst_async_ready", 64'(bus.req_ready), 64'h0);
        checkOutput("rst_async_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        checkOutput("rst_async_rsp_id", 64'(bus.rsp_id), 64'h0);
        checkOutput("rst_async_rsp_result", 64'(bus.rsp_result), 64'h0);
        checkOutput("rst_async_fp_a", 64'(fpA), 64'h0);
        checkOutput("rst_async_fp_b", 64'(fpB), 64'h0);
        checkOutput("rst_async_fp_op", 64'(fpOp), 64'h0);
        mdlPtr = 0;
        @(negedge i_clk);
        driveRequests('0);
        i_rst_n  = 1'b1;
        sawValid = 1'b0;
        repeat (LAT + 4) begin
            @(negedge i_clk);
            #1;
            if (bus.rsp_valid) sawValid = 1'b1;
        end
        checkOutput("rst_no_rsp", 64'(sawValid), 64'h0);
        applyStimulus('1, 0, gotId, gotRes);
        checkOutput("rst_next_id", 64'(gotId), 64'h0);

        $display("[TB] directed vector table");
        foreach (vectors[n]) begin
            reqA[vectors[n].reqIdx]  = vectors[n].a;
            reqB[vectors[n].reqIdx]  = vectors[n].b;
            reqOp[vectors[n].reqIdx] = vectors[n].op;
            mask = '0;
            mask[vectors[n].reqIdx] = 1'b1;
            applyStimulus(mask, vectors[n].stall, gotId, gotRes);
            checkOutput("vec_id", 64'(gotId), 64'(vectors[n].expId));
            checkOutput("vec_result", 64'(gotRes), 64'(vectors[n].expRes));
        end

        $display("[TB] randomized requests");
        for (int iter = 0; iter < 30; iter++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                reqA[i]  = r2f(real'(int'($urandom_range(0, 2000))) - 1000.0);
                reqB[i]  = r2f(real'(int'($urandom_range(0, 2000))) - 1000.0);
                reqOp[i] = 1'($urandom_range(0, 1));
            end
            mask = NUM_REQ'($urandom_range(0, 15));
            if (mask == '0) begin
                driveRequests(mask);
                #1;
                checkOutput("idle_no_grant", 64'(bus.req_ready), 64'h0);
                @(posedge i_clk);
                @(negedge i_clk);
                #1;
                checkOutput("idle_no_rsp", 64'(bus.rsp_valid), 64'h0);
            end else begin
                applyStimulus(mask, int'($urandom_range(0, 3)), gotId, gotRes);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
